// File: rtl/inst_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// inst_sequencer
//
// Fetches instruction bytes from program memory over a req/ack handshake and
// holds the opcode for the ControlUnit. It fetches an optional immediate byte,
// then opens a one-cycle execute window. It owns the program counter.
//
// Ports
//   clk       in   clock, all state changes on rising edge
//   rst       in   asynchronous active-low reset
//   run       in   permit a new fetch (sampled in IDLE and at end of EXEC)
//   memReq    out  program memory read request
//   memAddr   out  read address (always pc)
//   memAck    in   read data valid; ignored while memReq=0
//   memData   in   read data
//   inst      out  latched opcode
//   genConst  in   instruction carries an immediate byte (sampled in DECODE)
//   loadAddr  in   instruction loads the PC (sampled in EXEC)
//   addrIn    in   jump target
//   constOut  out  latched immediate operand
//   execEn    out  one-cycle execute strobe
//   pc        out  program counter
//   busy      out  high in every state except IDLE
//
// State table
//   state   | meaning
//   IDLE    | waiting for run; no memory activity
//   FETCH   | requesting opcode at pc; latch into inst on ack
//   DECODE  | ControlUnit decodes inst; choose OPERAND or EXEC
//   OPERAND | requesting immediate at pc; latch into constOut on ack
//   EXEC    | execEn window; optional pc load; then FETCH or IDLE
// -----------------------------------------------------------------------------
module inst_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [7:0]        memData,
    output logic [7:0]        inst,
    input  logic              genConst,
    input  logic              loadAddr,
    input  logic [ADDR_W-1:0] addrIn,
    output logic [7:0]        constOut,
    output logic              execEn,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        OPERAND = 3'd3,
        EXEC    = 3'd4
    } seqState_t;

    seqState_t state;
    seqState_t nextState;

    logic fetchDone;
    logic operandDone;

    // Outputs decode straight from the state register, so an asynchronous
    // reset drops memReq/execEn/busy in the same instant.
    assign memReq      = (state == FETCH) || (state == OPERAND);
    assign memAddr     = pc;
    assign execEn      = (state == EXEC);
    assign busy        = (state != IDLE);
    assign fetchDone   = (state == FETCH) && memAck;
    assign operandDone = (state == OPERAND) && memAck;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (run) nextState = FETCH;
            FETCH:   if (memAck) nextState = DECODE;
            DECODE:  nextState = genConst ? OPERAND : EXEC;
            OPERAND: if (memAck) nextState = EXEC;
            EXEC:    nextState = run ? FETCH : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // The EXEC load and the operand increment never coincide in one cycle;
    // the load simply replaces whatever the operand fetch left in pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (fetchDone || operandDone) begin
            pc <= pc + 1'b1;
        end else if ((state == EXEC) && loadAddr) begin
            pc <= addrIn;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst <= 8'h00;
        end else if (fetchDone) begin
            inst <= memData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            constOut <= 8'h00;
        end else if (operandDone) begin
            constOut <= memData;
        end
    end

endmodule
